// File: rtl/var_cmd_sequencer_pkg.sv
// Shared definitions for the variable register file command sequencer:
// FSM state encoding, command header field positions and default sizing.
package var_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_CAP   = 3'd4
  } state_t;

  // Header word layout
  localparam int unsigned OP_BIT   = 31;
  localparam int unsigned RSV_MSB  = 30;
  localparam int unsigned RSV_LSB  = 28;
  localparam int unsigned LEN_MSB  = 27;
  localparam int unsigned LEN_LSB  = 16;
  localparam int unsigned ADDR_MSB = 15;

  localparam int unsigned NUM_VARS_DEF = 76;

endpackage

// File: rtl/var_cmd_sequencer_if.sv
// Bundles the command FIFO, response FIFO and register-file port signals.
// master = the sequencer, slave = the FIFOs / register file around it.
interface var_cmd_sequencer_if;

  logic [31:0] cmd_data;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic [31:0] rsp_data;
  logic        rsp_wr_en;
  logic        rsp_full;
  logic        reg_wr_en;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    input  cmd_data, cmd_empty, rsp_full, reg_rdata,
    output cmd_rd_en, rsp_data, rsp_wr_en, reg_wr_en, reg_addr, reg_wdata
  );

  modport slave (
    output cmd_data, cmd_empty, rsp_full, reg_rdata,
    input  cmd_rd_en, rsp_data, rsp_wr_en, reg_wr_en, reg_addr, reg_wdata
  );

endinterface

// File: rtl/var_cmd_sequencer.sv
// Command-stream initiator: pops burst write/read commands from an FWFT
// command FIFO, drives the variable register file port, and pushes read
// results into the response FIFO.
module var_cmd_sequencer
  import var_cmd_sequencer_pkg::*;
#(
  parameter int unsigned NUM_VARS = NUM_VARS_DEF,
  parameter int unsigned LEN_W    = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  var_cmd_sequencer_if.master bus,
  input  logic                abort,
  input  logic                err_clr,
  output logic                busy,
  output logic                err_range,
  output logic                err_hdr,
  output logic [15:0]         cmd_done_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        addr;
  logic [LEN_W-1:0]   cnt;

  logic               pop;
  logic               hdr_take;
  logic               hdr_bad;
  logic               word_take;
  logic               rd_issue;
  logic               rd_cap;
  logic               done;

  logic               wr_en;
  logic [31:0]        addr_out;
  logic [31:0]        wdata;
  logic [31:0]        rsp_word;
  logic               rsp_push;

  logic               hdr_rsv_set;
  logic [LEN_W-1:0]   hdr_len;
  logic               addr_valid;

  function automatic logic in_range(input logic [31:0] a);
    return a < NUM_VARS;
  endfunction

  assign hdr_rsv_set = |bus.cmd_data[RSV_MSB:RSV_LSB];
  assign hdr_len     = LEN_W'(bus.cmd_data[LEN_MSB:LEN_LSB]);
  assign addr_valid  = in_range(addr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and pop/transfer qualifiers; abort overrides all of it
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    hdr_take  = 1'b0;
    hdr_bad   = 1'b0;
    word_take = 1'b0;
    rd_issue  = 1'b0;
    rd_cap    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.cmd_empty) begin
          pop = 1'b1;
          if (hdr_rsv_set) begin
            hdr_bad = 1'b1;
          end else if (hdr_len == '0) begin
            done = 1'b1;
          end else begin
            hdr_take  = 1'b1;
            state_nxt = bus.cmd_data[OP_BIT] ? ST_RD_ISSUE : ST_WR;
          end
        end
      end
      ST_WR: begin
        if (!bus.cmd_empty) begin
          pop       = 1'b1;
          word_take = 1'b1;
          if (cnt == LEN_W'(1)) begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_RD_ISSUE: begin
        // Only one read is ever in flight, so checking full here suffices
        if (!bus.rsp_full) begin
          rd_issue  = 1'b1;
          state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        state_nxt = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        rd_cap = 1'b1;
        if (cnt == LEN_W'(1)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RD_ISSUE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      pop       = 1'b0;
      hdr_take  = 1'b0;
      hdr_bad   = 1'b0;
      word_take = 1'b0;
      rd_issue  = 1'b0;
      rd_cap    = 1'b0;
      done      = 1'b0;
    end
  end

  // Burst address/count tracking and registered register-file/response ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      cnt      <= '0;
      wr_en    <= 1'b0;
      addr_out <= '0;
      wdata    <= '0;
      rsp_word <= '0;
      rsp_push <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      rsp_push <= 1'b0;
      if (hdr_take) begin
        addr <= {16'h0, bus.cmd_data[ADDR_MSB:0]};
        cnt  <= hdr_len;
      end
      if (word_take) begin
        // Out-of-range words are consumed but never reach the register file
        if (addr_valid) begin
          wr_en    <= 1'b1;
          addr_out <= addr;
          wdata    <= bus.cmd_data;
        end
        addr <= addr + 32'd1;
        cnt  <= cnt - LEN_W'(1);
      end
      if (rd_issue) begin
        addr_out <= addr;
      end
      if (rd_cap) begin
        rsp_word <= addr_valid ? bus.reg_rdata : 32'h0;
        rsp_push <= 1'b1;
        addr     <= addr + 32'd1;
        cnt      <= cnt - LEN_W'(1);
      end
    end
  end

  // Sticky error flags (a same-cycle set beats err_clr) and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range    <= 1'b0;
      err_hdr      <= 1'b0;
      cmd_done_cnt <= '0;
    end else begin
      if ((word_take || rd_cap) && !addr_valid) begin
        err_range <= 1'b1;
      end else if (err_clr) begin
        err_range <= 1'b0;
      end
      if (hdr_bad) begin
        err_hdr <= 1'b1;
      end else if (err_clr) begin
        err_hdr <= 1'b0;
      end
      if (done) begin
        cmd_done_cnt <= cmd_done_cnt + 16'd1;
      end
    end
  end

  assign busy          = (state != ST_IDLE);
  assign bus.cmd_rd_en = pop;
  assign bus.reg_wr_en = wr_en;
  assign bus.reg_addr  = addr_out;
  assign bus.reg_wdata = wdata;
  assign bus.rsp_data  = rsp_word;
  assign bus.rsp_wr_en = rsp_push;

endmodule

// File: tb/tb_var_cmd_sequencer.sv
// Directed bench for var_cmd_sequencer: models the command FIFO, the
// response FIFO sink and a 76-entry register file with registered readback.
module tb_var_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        err_clr;
  logic        busy;
  logic        err_range;
  logic        err_hdr;
  logic [15:0] cmd_done_cnt;

  var_cmd_sequencer_if bus();

  var_cmd_sequencer #(.NUM_VARS(76), .LEN_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .abort        (abort),
    .err_clr      (err_clr),
    .busy         (busy),
    .err_range    (err_range),
    .err_hdr      (err_hdr),
    .cmd_done_cnt (cmd_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Command FIFO model
  logic [31:0] fifo [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cyc [0:63];

  assign bus.cmd_empty = (rd_ptr == wr_ptr);
  assign bus.cmd_data  = (rd_ptr != wr_ptr) ? fifo[rd_ptr] : 32'h0;

  // Register file model and logs
  logic [31:0] mem [0:75];
  logic [31:0] rf_rdata = 32'h0;
  logic        rsp_full;
  assign bus.reg_rdata = rf_rdata;
  assign bus.rsp_full  = rsp_full;

  int          cyc = 0;
  int          wr_n = 0;
  logic [31:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  int          wr_cyc  [0:31];
  int          rsp_n = 0;
  logic [31:0] rsp_val [0:31];
  int          rsp_cyc [0:31];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cmd_rd_en && rd_ptr != wr_ptr) begin
      pop_cyc[rd_ptr] <= cyc;
      rd_ptr <= rd_ptr + 1;
    end
    if (bus.reg_wr_en) begin
      if (bus.reg_addr < 32'd76) mem[bus.reg_addr[6:0]] <= bus.reg_wdata;
      wr_addr[wr_n] <= bus.reg_addr;
      wr_data[wr_n] <= bus.reg_wdata;
      wr_cyc[wr_n]  <= cyc;
      wr_n <= wr_n + 1;
    end else begin
      rf_rdata <= (bus.reg_addr < 32'd76) ? mem[bus.reg_addr[6:0]] : 32'h0;
    end
    if (bus.rsp_wr_en) begin
      rsp_val[rsp_n] <= bus.rsp_data;
      rsp_cyc[rsp_n] <= cyc;
      rsp_n <= rsp_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    step();
    while ((busy || rd_ptr != wr_ptr) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected<%0d", tag, n, budget);
    end
    step(2);
  endtask

  int wr_base;
  int rsp_base;
  int h;

  initial begin
    rst_n    = 1'b0;
    abort    = 1'b0;
    err_clr  = 1'b0;
    rsp_full = 1'b0;
    step(3);
    // Reset state
    check("rst_busy",      32'(busy),          32'h0);
    check("rst_cmd_rd_en", 32'(bus.cmd_rd_en), 32'h0);
    check("rst_reg_wr_en", 32'(bus.reg_wr_en), 32'h0);
    check("rst_reg_addr",  bus.reg_addr,       32'h0);
    check("rst_rsp_wr_en", 32'(bus.rsp_wr_en), 32'h0);
    check("rst_rsp_data",  bus.rsp_data,       32'h0);
    check("rst_errs",      {30'h0, err_range, err_hdr}, 32'h0);
    check("rst_done_cnt",  32'(cmd_done_cnt),  32'h0);
    rst_n = 1'b1;
    step(2);

    // Write burst: addr 0..2 <= 5,7,9
    h = wr_ptr;
    push(32'h0003_0000); push(32'd5); push(32'd7); push(32'd9);
    wait_idle("wr_burst", 50);
    check("wr_count", 32'(wr_n), 32'd3);
    check("wr0", {wr_addr[0][15:0], wr_data[0][15:0]}, {16'd0, 16'd5});
    check("wr1", {wr_addr[1][15:0], wr_data[1][15:0]}, {16'd1, 16'd7});
    check("wr2", {wr_addr[2][15:0], wr_data[2][15:0]}, {16'd2, 16'd9});
    check("wr_hdr_to_first", 32'(wr_cyc[0] - pop_cyc[h]), 32'd2);
    check("wr_back_to_back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    check("wr_done_cnt", 32'(cmd_done_cnt), 32'd1);

    // Read burst of the same three addresses
    h = wr_ptr;
    push(32'h8003_0000);
    wait_idle("rd_burst", 60);
    check("rd_count", 32'(rsp_n), 32'd3);
    check("rd0", rsp_val[0], 32'd5);
    check("rd1", rsp_val[1], 32'd7);
    check("rd2", rsp_val[2], 32'd9);
    check("rd_latency", 32'(rsp_cyc[0] - pop_cyc[h]), 32'd4);
    check("rd_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd3);
    check("rd_no_writes", 32'(wr_n), 32'd3);
    check("rd_mem_kept", mem[1], 32'd7);
    check("rd_done_cnt", 32'(cmd_done_cnt), 32'd2);

    // Backpressure: read len 2 from addr 1 with the response FIFO full
    rsp_full = 1'b1;
    push(32'h8002_0001);
    step(8);
    check("bp_no_push", 32'(rsp_n), 32'd3);
    check("bp_addr_held", bus.reg_addr, 32'd2);
    check("bp_busy", 32'(busy), 32'd1);
    rsp_full = 1'b0;
    wait_idle("bp_release", 60);
    check("bp_count", 32'(rsp_n), 32'd5);
    check("bp_rd0", rsp_val[3], 32'd7);
    check("bp_rd1", rsp_val[4], 32'd9);
    check("bp_done_cnt", 32'(cmd_done_cnt), 32'd3);

    // Range: addr 75 written, addr 76 dropped and flagged
    wr_base = wr_n;
    push(32'h0002_004B); push(32'd1); push(32'd2);
    wait_idle("range", 50);
    check("range_one_write", 32'(wr_n - wr_base), 32'd1);
    check("range_addr", wr_addr[wr_base], 32'd75);
    check("range_data", wr_data[wr_base], 32'd1);
    check("range_all_popped", 32'(wr_ptr - rd_ptr), 32'd0);
    check("range_err", 32'(err_range), 32'd1);
    check("range_done_cnt", 32'(cmd_done_cnt), 32'd4);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("range_err_clr", 32'(err_range), 32'd0);

    // Reserved bits and len 0
    wr_base = wr_n;
    push(32'h1000_0000);
    wait_idle("hdr_rsv", 20);
    check("hdr_err", 32'(err_hdr), 32'd1);
    check("hdr_done_cnt", 32'(cmd_done_cnt), 32'd4);
    push(32'h0000_0005);
    wait_idle("len0", 20);
    check("len0_done_cnt", 32'(cmd_done_cnt), 32'd5);
    check("hdr_no_write", 32'(wr_n - wr_base), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("hdr_err_clr", 32'(err_hdr), 32'd0);
    push(32'h2000_0000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("hdr_set_beats_clr", 32'(err_hdr), 32'd1);

    // Abort a len-4 write after two words
    wr_base = wr_n;
    push(32'h0004_0010); push(32'h0000_000A); push(32'h0000_000B);
    step(6);
    check("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done_cnt", 32'(cmd_done_cnt), 32'd5);
    step(2);
    check("abort_writes", 32'(wr_n - wr_base), 32'd2);
    check("abort_wr1", {wr_addr[wr_base + 1][15:0], wr_data[wr_base + 1][15:0]}, {16'h0011, 16'h000B});

    // Asynchronous reset mid-read (addr 2 holds 9)
    push(32'h8003_0002);
    step(4);
    check("mid_rd_push", 32'(bus.rsp_wr_en), 32'd1);
    check("mid_rd_data", bus.rsp_data, 32'd9);
    check("mid_rd_addr", bus.reg_addr, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",      32'(busy),          32'h0);
    check("arst_rsp_wr_en", 32'(bus.rsp_wr_en), 32'h0);
    check("arst_rsp_data",  bus.rsp_data,       32'h0);
    check("arst_reg_addr",  bus.reg_addr,       32'h0);
    check("arst_errs",      {30'h0, err_range, err_hdr}, 32'h0);
    check("arst_done_cnt",  32'(cmd_done_cnt),  32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/var_cmd_sequencer.md
# var_cmd_sequencer

Command-stream initiator for the variable register file's write/readback port. It pops host command words from a first-word-fall-through (FWFT) pipe-in FIFO and decodes burst write and burst read commands. It drives the register file's wr_en/address/value port and pushes readback values into a pipe-out response FIFO. It sits between the host endpoint FIFOs and the variable register file, replacing direct host pokes of the register port.

## Interface
Parameters:
- NUM_VARS, 76: number of valid variable addresses, 0..NUM_VARS-1.
- LEN_W, 12: width of the burst-length field.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_data  in  32  head word of the command FIFO (FWFT).
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  pop strobe, combinational; asserted only when cmd_empty=0.
- rsp_data  out  32  readback word, registered.
- rsp_wr_en  out  1  one-cycle push strobe, registered.
- rsp_full  in  1  response FIFO full.
- reg_wr_en  out  1  register-file write enable, registered.
- reg_addr  out  32  register-file address, registered.
- reg_wdata  out  32  register-file write value, registered.
- reg_rdata  in  32  register-file readback (register file's registered output).
- abort  in  1  synchronous: return to IDLE at the next edge, discarding the rest of the current command.
- err_clr  in  1  synchronous clear of the sticky error flags.
- busy  out  1  high in any state other than IDLE.
- err_range  out  1  sticky: an access targeted an address ≥ NUM_VARS.
- err_hdr  out  1  sticky: header had nonzero reserved bits.
- cmd_done_cnt  out  16  completed-command counter; wraps at 2^16.

## Operation
Header word format:
- [31]: op, 0 = write, 1 = read.
- [30:28]: reserved, must be 0.
- [27:16]: len, 0..4095.
- [15:0]: start address.

States:
- IDLE: when cmd_empty=0, pop the header and latch op, len and addr.
  - Reserved bits ≠ 0: set err_hdr, discard the header, stay in IDLE. The next word is parsed as a header.
  - len = 0: no-op; increment cmd_done_cnt, stay in IDLE.
  - Otherwise go to WR or RD_ISSUE according to op.
- WR: on each cycle with cmd_empty=0, pop one word, then on the next cycle:
  - reg_wr_en=1, reg_addr=addr, reg_wdata=word.
  - Then increment addr and decrement the remaining count.
  - If addr ≥ NUM_VARS, keep reg_wr_en=0 (the word is still consumed) and set err_range.
  - cmd_empty=1 mid-burst: wait indefinitely with reg_wr_en=0.
  - After the last word: cmd_done_cnt+1, go to IDLE.
- RD_ISSUE: wait until rsp_full=0, then reg_addr<=addr, go to RD_WAIT.
- RD_WAIT: one cycle; the register file samples the address at the end of this cycle.
- RD_CAP: rsp_data<=reg_rdata (0 if addr ≥ NUM_VARS, also sets err_range), rsp_wr_en<=1. Then increment addr and decrement the count.
  - Count remaining: back to RD_ISSUE.
  - Last word: cmd_done_cnt+1, go to IDLE.
- reg_wr_en is 0 in every state except the WR write cycle. The register file updates its readback only when wr_en is low.

Arithmetic and priority:
- addr is held in 32 bits and increments without wrap.
- The 16-bit header address is zero-extended.
- err_clr and a same-cycle error event: the set wins.
- abort has priority over everything:
  - No further pops after the abort edge.
  - A strobe already registered (reg_wr_en, rsp_wr_en) completes.
  - cmd_done_cnt is not incremented.

## Timing
- Reset values: all outputs 0; state IDLE; cmd_done_cnt 0.
- Write latency: pop at cycle k → reg_wr_en high during k+1. Sustained throughput is 1 word/cycle with the FIFO non-empty.
- Header pop to first write: 2 cycles.
- Read latency: RD_ISSUE accept at k → rsp_wr_en high at k+3. Throughput is 1 word / 3 cycles. Only one read is in flight, so checking rsp_full in RD_ISSUE alone is sufficient.
- cmd_rd_en is a combinational function of state and cmd_empty; never more than 1 pop per cycle.
- Reset mid-burst: immediate return to IDLE and outputs cleared. Unconsumed burst words remain in the FIFO and are later parsed as headers; the host flushes the FIFO on reset.

## Structure
- Shared package:
  - State enum.
  - Header field positions: OP_BIT=31, RSV_MSB=30, RSV_LSB=28, LEN_MSB=27, LEN_LSB=16, ADDR_MSB=15.
  - NUM_VARS default.
- Single flat module; no sub-module warranted. The datapath is the addr/count registers plus the output flops.

## Test plan
- Write burst: header 0x0003_0000, data 5, 7, 9 → reg_wr_en pulses with (0,5), (1,7), (2,9) on consecutive cycles; cmd_done_cnt=1.
- Read burst after the write: header 0x8003_0000 → rsp pushes 5, 7, 9, each 3 cycles apart; register file unchanged.
- Range: write header 0x0002_004B (addr 75), data 1, 2 → a single write to addr 75 only; err_range=1; both data words popped. err_clr → 0.
- Backpressure: rsp_full=1 while a read of len 2 is pending → no rsp_wr_en and no address change. Release → both words delivered in order.
- Reserved bits / len 0: header 0x1000_0000 → err_hdr=1, no write. Header 0x0000_0005 → no-op, cmd_done_cnt increments.
- Abort/reset mid-operation: abort during a write of len 4 after 2 words → exactly 2 writes; busy=0 next cycle; count unchanged. rst_n pulse mid-read → all outputs 0 asynchronously.
